// File: rtl/wb_commit_mp_pkg.sv
// Shared definitions for the multi-lane writeback/commit stage: lane payload layout,
// exception codes and FSM states.
package wb_commit_mp_pkg;

  localparam int LANE_WD   = 110;
  localparam int RF_BUS_WD = 38;

  // Code 0x1f is reserved by the architecture, so it marks "no exception".
  localparam logic [4:0] NO_EX   = 5'h1f;
  localparam logic [4:0] EX_ADEL = 5'h04;
  localparam logic [4:0] EX_ADES = 5'h05;

  localparam int OFF_PC       = 0;
  localparam int OFF_RESULT   = 32;
  localparam int OFF_DEST     = 64;
  localparam int OFF_GR_WE    = 69;
  localparam int OFF_BD       = 70;
  localparam int OFF_ERET     = 71;
  localparam int OFF_EX_CODE  = 72;
  localparam int OFF_BADVADDR = 77;
  localparam int OFF_PC_ERROR = 109;

  typedef struct packed {
    logic        pc_error;
    logic [31:0] badvaddr;
    logic [4:0]  ex_code;
    logic        eret;
    logic        bd;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } lane_t;

  typedef enum logic {ST_RUN, ST_FLUSH} ws_state_e;

  function automatic lane_t unpack_lane(input logic [LANE_WD-1:0] raw);
    lane_t l;
    l.pc       = raw[OFF_PC +: 32];
    l.result   = raw[OFF_RESULT +: 32];
    l.dest     = raw[OFF_DEST +: 5];
    l.gr_we    = raw[OFF_GR_WE];
    l.bd       = raw[OFF_BD];
    l.eret     = raw[OFF_ERET];
    l.ex_code  = raw[OFF_EX_CODE +: 5];
    l.badvaddr = raw[OFF_BADVADDR +: 32];
    l.pc_error = raw[OFF_PC_ERROR];
    return l;
  endfunction

endpackage

// File: rtl/wb_commit_mp_fault_pick.sv
// Priority encoder: finds the oldest faulting lane and masks it and every younger lane
// out of the commit set.
module wb_fault_pick #(
  parameter int LANES = 2,
  parameter int KW    = 1
) (
  input  logic [LANES-1:0] valid_i,
  input  logic [LANES-1:0] raw_fault_i,
  output logic             fault_o,
  output logic [KW-1:0]    k_o,
  output logic [LANES-1:0] commit_o
);

  always_comb begin
    fault_o  = 1'b0;
    k_o      = '0;
    commit_o = '0;
    for (int i = 0; i < LANES; i++) begin
      if (valid_i[i] && raw_fault_i[i] && !fault_o) begin
        fault_o = 1'b1;
        k_o     = KW'(i);
      end
      commit_o[i] = valid_i[i] && !fault_o;
    end
  end

endmodule

// File: rtl/wb_commit_mp.sv
// Multi-lane writeback/commit stage: in-order commit of up to LANES instructions,
// precise exception/ERET resolution on the oldest faulting lane and a post-fault flush window.
module wb_commit_mp
  import wb_commit_mp_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  output logic                         ws_allowin,
  input  logic [LANES-1:0]             ms_to_ws_valid,
  input  logic [LANES*LANE_WD-1:0]     ms_to_ws_bus,
  output logic [LANES*RF_BUS_WD-1:0]   ws_to_rf_bus,
  output logic [LANES*5-1:0]           ws_dest,
  output logic [LANES*32-1:0]          ws_dest_data,
  output logic                         ws_ex,
  output logic                         ws_eret,
  output logic [4:0]                   cp0_ex_code,
  output logic                         cp0_ex_bd,
  output logic [31:0]                  cp0_ex_epc,
  output logic [31:0]                  cp0_badvaddr,
  output logic                         cp0_badvaddr_we,
  output logic                         flushing,
  output logic [CNT_W-1:0]             retire_cnt,
  output logic [LANES*32-1:0]          debug_wb_pc,
  output logic [LANES*4-1:0]           debug_wb_rf_wen,
  output logic [LANES*5-1:0]           debug_wb_rf_wnum,
  output logic [LANES*32-1:0]          debug_wb_rf_wdata
);

  localparam int KW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYC > 0) ? 4'(FLUSH_CYC - 1) : 4'd0;

  ws_state_e                state_q;
  logic [3:0]               flush_cnt_q;
  logic [LANES-1:0]         valid_q;
  logic [LANES*LANE_WD-1:0] bus_q;
  logic [CNT_W-1:0]         retire_q, retire_d;

  lane_t            lane [LANES];
  lane_t            sel;
  logic [LANES-1:0] raw_fault, commit, we;
  logic             fault;
  logic [KW-1:0]    k;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane[i]      = unpack_lane(bus_q[i*LANE_WD +: LANE_WD]);
      raw_fault[i] = (lane[i].ex_code != NO_EX) || lane[i].eret;
    end
  end

  wb_fault_pick #(.LANES(LANES), .KW(KW)) u_fault_pick (
    .valid_i     (valid_q),
    .raw_fault_i (raw_fault),
    .fault_o     (fault),
    .k_o         (k),
    .commit_o    (commit)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < LANES; i++) begin
      if (k == KW'(i)) sel = lane[i];
    end
  end

  always_comb begin
    we                = '0;
    retire_d          = retire_q;
    ws_to_rf_bus      = '0;
    ws_dest           = '0;
    ws_dest_data      = '0;
    debug_wb_pc       = '0;
    debug_wb_rf_wen   = '0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    for (int i = 0; i < LANES; i++) begin
      we[i] = commit[i] & lane[i].gr_we;
      ws_to_rf_bus[i*RF_BUS_WD +: RF_BUS_WD] = {we[i], lane[i].dest, lane[i].result};
      // Faulting and younger lanes keep reporting dest so hazard checks stay conservative.
      ws_dest[i*5 +: 5]            = lane[i].dest & {5{valid_q[i]}};
      ws_dest_data[i*32 +: 32]     = lane[i].result;
      debug_wb_pc[i*32 +: 32]      = lane[i].pc;
      debug_wb_rf_wen[i*4 +: 4]    = {4{we[i]}};
      debug_wb_rf_wnum[i*5 +: 5]   = lane[i].dest;
      debug_wb_rf_wdata[i*32 +: 32] = lane[i].result;
      retire_d = retire_d + CNT_W'(commit[i]);
    end
  end

  assign ws_allowin      = 1'b1;
  assign ws_ex           = fault & (sel.ex_code != NO_EX);
  assign ws_eret         = fault & sel.eret & (sel.ex_code == NO_EX);
  assign cp0_ex_code     = fault ? sel.ex_code  : 5'd0;
  assign cp0_ex_bd       = fault & sel.bd;
  assign cp0_ex_epc      = fault ? sel.pc       : 32'd0;
  assign cp0_badvaddr    = fault ? sel.badvaddr : 32'd0;
  assign cp0_badvaddr_we = fault & (sel.pc_error | (sel.ex_code == EX_ADEL) | (sel.ex_code == EX_ADES));
  assign flushing        = (state_q == ST_FLUSH);
  assign retire_cnt      = retire_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 4'd0;
      valid_q     <= '0;
      retire_q    <= '0;
    end else begin
      retire_q <= retire_d;
      case (state_q)
        ST_RUN: begin
          if (fault) begin
            // The bundle offered in the fault cycle is younger than the fault: drop it.
            valid_q <= '0;
            if (FLUSH_CYC > 0) begin
              state_q     <= ST_FLUSH;
              flush_cnt_q <= FLUSH_LOAD;
            end
          end else begin
            valid_q <= ms_to_ws_valid;
            if (|ms_to_ws_valid) bus_q <= ms_to_ws_bus;
          end
        end
        ST_FLUSH: begin
          valid_q <= '0;
          if (flush_cnt_q == 4'd0) state_q <= ST_RUN;
          else flush_cnt_q <= flush_cnt_q - 4'd1;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule
